// File: rtl/data_merge_pkg.sv
// Shared types and constants for the data_merge frame merger: FSM states,
// metadata field layout, source encoding and counter saturation limits.
package data_merge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        META = 2'd2
    } state_t;

    localparam int MD_BYTES_LSB = 0;
    localparam int MD_BYTES_W   = 32;
    localparam int MD_BEATS_LSB = 32;
    localparam int MD_BEATS_W   = 16;
    localparam int MD_SRC_BIT   = 48;
    localparam int MD_OVER_BIT  = 49;
    localparam int MD_GAP_BIT   = 50;

    localparam logic SRC_IN1 = 1'b0;
    localparam logic SRC_IN2 = 1'b1;

    localparam logic [15:0] BEAT_SAT = 16'hFFFF;
    localparam logic [31:0] BYTE_SAT = 32'hFFFF_FFFF;

    // Byte accumulation clamps at the limit instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? BYTE_SAT : s[31:0];
    endfunction

endpackage

// File: rtl/data_merge_keep.sv
// keep_popcount: combinational count of asserted TKEEP bits (bytes in a beat).
module keep_popcount #(
    parameter  int DW = 512,
    localparam int KW = DW / 8,
    localparam int CW = $clog2(KW) + 1
) (
    input  logic [KW-1:0] i_keep,
    output logic [CW-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < KW; i++) begin
            o_count = o_count + CW'(i_keep[i]);
        end
    end

endmodule

// File: rtl/data_merge.sv
// data_merge: frame-atomic 2:1 AXI-Stream merger with per-frame metadata beat.
// Build option DATA_MERGE_STRICT_PRIORITY_EN: IN1 always wins ties (default round-robin).
module data_merge
    import data_merge_pkg::*;
#(
    parameter int DW = 512
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       FRAME_SIZE,

    input  logic [DW-1:0]     AXIS_IN1_TDATA,
    input  logic [DW/8-1:0]   AXIS_IN1_TKEEP,
    input  logic              AXIS_IN1_TLAST,
    input  logic              AXIS_IN1_TVALID,
    output logic              AXIS_IN1_TREADY,

    input  logic [DW-1:0]     AXIS_IN2_TDATA,
    input  logic [DW/8-1:0]   AXIS_IN2_TKEEP,
    input  logic              AXIS_IN2_TLAST,
    input  logic              AXIS_IN2_TVALID,
    output logic              AXIS_IN2_TREADY,

    output logic [DW-1:0]     AXIS_OUT_FD_TDATA,
    output logic [DW/8-1:0]   AXIS_OUT_FD_TKEEP,
    output logic              AXIS_OUT_FD_TLAST,
    output logic              AXIS_OUT_FD_TVALID,
    input  logic              AXIS_OUT_FD_TREADY,

    output logic [DW-1:0]     AXIS_OUT_MD_TDATA,
    output logic              AXIS_OUT_MD_TVALID,
    input  logic              AXIS_OUT_MD_TREADY,

    output logic [1:0]        o_dbg_state
);

    localparam int KW = DW / 8;
    localparam int CW = $clog2(KW) + 1;

    // Handshake rule on every stream: a beat transfers on a rising edge where
    // TVALID and TREADY are both 1; a producer holds TVALID and payload steady
    // until then, and TREADY is never derived from the same port's TVALID.

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_grant;
    logic            w_grant_nxt;

    logic [15:0]     r_beat_cnt;
    logic [31:0]     r_byte_cnt;
    logic            r_gap;

    logic [DW-1:0]   r_fd_data;
    logic [KW-1:0]   r_fd_keep;
    logic            r_fd_last;
    logic            r_fd_valid;
    logic [DW-1:0]   r_md_data;
    logic            r_md_valid;

`ifndef DATA_MERGE_STRICT_PRIORITY_EN
    logic            r_last_src;
`endif

    logic [DW-1:0]   w_sel_data;
    logic [KW-1:0]   w_sel_keep;
    logic            w_sel_last;
    logic            w_sel_valid;
    logic            w_fd_free;
    logic            w_md_free;
    logic            w_accept;
    logic            w_md_load;
    logic [CW-1:0]   w_popcnt;
    logic [DW-1:0]   w_md_next;

    assign w_sel_data  = (r_grant == SRC_IN2) ? AXIS_IN2_TDATA  : AXIS_IN1_TDATA;
    assign w_sel_keep  = (r_grant == SRC_IN2) ? AXIS_IN2_TKEEP  : AXIS_IN1_TKEEP;
    assign w_sel_last  = (r_grant == SRC_IN2) ? AXIS_IN2_TLAST  : AXIS_IN1_TLAST;
    assign w_sel_valid = (r_grant == SRC_IN2) ? AXIS_IN2_TVALID : AXIS_IN1_TVALID;

    assign w_fd_free = !r_fd_valid || AXIS_OUT_FD_TREADY;
    assign w_md_free = !r_md_valid || AXIS_OUT_MD_TREADY;

    assign AXIS_IN1_TREADY = (r_state == PASS) && (r_grant == SRC_IN1) && w_fd_free;
    assign AXIS_IN2_TREADY = (r_state == PASS) && (r_grant == SRC_IN2) && w_fd_free;

    assign w_accept  = (r_state == PASS) && w_sel_valid && w_fd_free;
    assign w_md_load = (r_state == META) && w_md_free;

    keep_popcount #(.DW(DW)) u_keep_popcount (
        .i_keep  (w_sel_keep),
        .o_count (w_popcnt)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_grant <= SRC_IN1;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            IDLE: begin
                if (AXIS_IN1_TVALID || AXIS_IN2_TVALID) begin
                    w_state_nxt = PASS;
                    if (AXIS_IN1_TVALID && AXIS_IN2_TVALID) begin
`ifdef DATA_MERGE_STRICT_PRIORITY_EN
                        w_grant_nxt = SRC_IN1;
`else
                        w_grant_nxt = (r_last_src == SRC_IN1) ? SRC_IN2 : SRC_IN1;
`endif
                    end else begin
                        w_grant_nxt = AXIS_IN2_TVALID ? SRC_IN2 : SRC_IN1;
                    end
                end
            end
            PASS: begin
                if (w_accept && w_sel_last) begin
                    w_state_nxt = META;
                end
            end
            META: begin
                if (w_md_free) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_md_next = '0;
        w_md_next[MD_BYTES_LSB +: MD_BYTES_W] = r_byte_cnt;
        w_md_next[MD_BEATS_LSB +: MD_BEATS_W] = r_beat_cnt;
        w_md_next[MD_SRC_BIT]  = r_grant;
        w_md_next[MD_OVER_BIT] = (r_byte_cnt > FRAME_SIZE);
        w_md_next[MD_GAP_BIT]  = r_gap;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_fd_data  <= '0;
            r_fd_keep  <= '0;
            r_fd_last  <= 1'b0;
            r_fd_valid <= 1'b0;
            r_md_data  <= '0;
            r_md_valid <= 1'b0;
            r_beat_cnt <= '0;
            r_byte_cnt <= '0;
            r_gap      <= 1'b0;
`ifndef DATA_MERGE_STRICT_PRIORITY_EN
            r_last_src <= SRC_IN2;
`endif
        end else begin
            if (w_accept) begin
                r_fd_data  <= w_sel_data;
                r_fd_keep  <= w_sel_keep;
                r_fd_last  <= w_sel_last;
                r_fd_valid <= 1'b1;
            end else if (AXIS_OUT_FD_TREADY) begin
                r_fd_valid <= 1'b0;
            end

            // Counters restart every IDLE cycle so a new frame always begins at zero.
            if (r_state == IDLE) begin
                r_beat_cnt <= '0;
                r_byte_cnt <= '0;
                r_gap      <= 1'b0;
            end else if (w_accept) begin
                r_beat_cnt <= (r_beat_cnt == BEAT_SAT) ? BEAT_SAT : r_beat_cnt + 16'd1;
                r_byte_cnt <= sat_add32(r_byte_cnt, 32'(w_popcnt));
                if (!w_sel_last && (w_sel_keep != {KW{1'b1}})) begin
                    r_gap <= 1'b1;
                end
            end

            if (w_md_load) begin
                r_md_data  <= w_md_next;
                r_md_valid <= 1'b1;
`ifndef DATA_MERGE_STRICT_PRIORITY_EN
                r_last_src <= r_grant;
`endif
            end else if (AXIS_OUT_MD_TREADY) begin
                r_md_valid <= 1'b0;
            end
        end
    end

    assign AXIS_OUT_FD_TDATA  = r_fd_data;
    assign AXIS_OUT_FD_TKEEP  = r_fd_keep;
    assign AXIS_OUT_FD_TLAST  = r_fd_last;
    assign AXIS_OUT_FD_TVALID = r_fd_valid;
    assign AXIS_OUT_MD_TDATA  = r_md_data;
    assign AXIS_OUT_MD_TVALID = r_md_valid;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_data_merge.sv
// Self-checking bench for data_merge: random and directed frames on both inputs,
// frame-level reference model feeding per-source expected queues.
`timescale 1ns/1ps
module tb_data_merge;
    import data_merge_pkg::*;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int BW = DW + KW + 1;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [31:0]     frame_size;
    logic [DW-1:0]   in1_data, in2_data, fd_data, md_data;
    logic [KW-1:0]   in1_keep, in2_keep, fd_keep;
    logic            in1_last, in1_valid, in1_ready;
    logic            in2_last, in2_valid, in2_ready;
    logic            fd_last, fd_valid, fd_ready;
    logic            md_valid, md_ready;
    logic [1:0]      dbg_state;

    data_merge #(.DW(DW)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .FRAME_SIZE         (frame_size),
        .AXIS_IN1_TDATA     (in1_data),
        .AXIS_IN1_TKEEP     (in1_keep),
        .AXIS_IN1_TLAST     (in1_last),
        .AXIS_IN1_TVALID    (in1_valid),
        .AXIS_IN1_TREADY    (in1_ready),
        .AXIS_IN2_TDATA     (in2_data),
        .AXIS_IN2_TKEEP     (in2_keep),
        .AXIS_IN2_TLAST     (in2_last),
        .AXIS_IN2_TVALID    (in2_valid),
        .AXIS_IN2_TREADY    (in2_ready),
        .AXIS_OUT_FD_TDATA  (fd_data),
        .AXIS_OUT_FD_TKEEP  (fd_keep),
        .AXIS_OUT_FD_TLAST  (fd_last),
        .AXIS_OUT_FD_TVALID (fd_valid),
        .AXIS_OUT_FD_TREADY (fd_ready),
        .AXIS_OUT_MD_TDATA  (md_data),
        .AXIS_OUT_MD_TVALID (md_valid),
        .AXIS_OUT_MD_TREADY (md_ready),
        .o_dbg_state        (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [BW-1:0] tx1_q[$], tx2_q[$], exp1_q[$], exp2_q[$];
    logic [63:0]   md1_q[$], md2_q[$];
    bit            obs_order[$];
    bit            order_rec = 1'b0;
    bit            mon_in_frame = 1'b0;
    bit            mon_src = 1'b0;
    logic [DW-1:0] last_md = '0;

    int fd_mode = 0;   // 0 always ready, 1 random, 2 toggle
    int md_mode = 0;   // 0 always ready, 1 random, 2 held low
    bit gap_en = 1'b0;
    bit drv_hold = 1'b1;

    task automatic check(input string name, input logic [639:0] got, input logic [639:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic flush_sb();
        tx1_q.delete(); tx2_q.delete();
        exp1_q.delete(); exp2_q.delete();
        md1_q.delete(); md2_q.delete();
        mon_in_frame = 1'b0;
    endtask

    // Reference model: one frame -> its beats and its metadata word.
    task automatic build_frame(input bit src, input int nbeats, input int kmode,
                               input logic [KW-1:0] last_keep);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [BW-1:0] b;
        logic [63:0]   md;
        int            bytes;
        bit            gap;
        bytes = 0;
        gap = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
            d[0] = src;
            if (kmode == 0) begin
                k = (i == nbeats - 1) ? last_keep : {KW{1'b1}};
            end else begin
                case ($urandom_range(0, 5))
                    0:       k = '0;
                    1:       k = {$urandom, $urandom};
                    default: k = {KW{1'b1}};
                endcase
            end
            bytes += $countones(k);
            if ((i != nbeats - 1) && (k != {KW{1'b1}})) gap = 1'b1;
            b = {(i == nbeats - 1), k, d};
            if (src) begin tx2_q.push_back(b); exp2_q.push_back(b); end
            else     begin tx1_q.push_back(b); exp1_q.push_back(b); end
        end
        md = '0;
        md[31:0]  = 32'(bytes);
        md[47:32] = 16'(nbeats);
        md[48]    = src;
        md[49]    = (32'(bytes) > frame_size);
        md[50]    = gap;
        if (src) md2_q.push_back(md);
        else     md1_q.push_back(md);
    endtask

    // ---------------- drivers ----------------
    task automatic set_port(input bit src, input bit v, input logic [BW-1:0] b);
        if (src) begin
            in2_valid = v;
            {in2_last, in2_keep, in2_data} = b;
        end else begin
            in1_valid = v;
            {in1_last, in1_keep, in1_data} = b;
        end
    endtask

    task automatic driver(input bit src);
        logic [BW-1:0] b;
        bit hs;
        int wc;
        @(posedge clk); #1;
        forever begin
            if (drv_hold) begin
                @(posedge clk); #1;
            end else if ((src ? tx2_q.size() : tx1_q.size()) == 0 ||
                         (gap_en && $urandom_range(0, 3) == 0)) begin
                set_port(src, 1'b0, '0);
                @(posedge clk); #1;
            end else begin
                b = src ? tx2_q.pop_front() : tx1_q.pop_front();
                set_port(src, 1'b1, b);
                wc = 0;
                do begin
                    @(negedge clk);
                    hs = src ? in2_ready : in1_ready;
                    @(posedge clk); #1;
                    wc++;
                end while (!hs && wc < 3000);
                check(src ? "drv_in2_handshake" : "drv_in1_handshake", 640'(hs), 640'(1));
            end
        end
    endtask

    initial driver(1'b0);
    initial driver(1'b1);

    // ---------------- sinks ----------------
    initial begin
        fd_ready = 1'b0;
        md_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (fd_mode)
                0:       fd_ready = 1'b1;
                1:       fd_ready = ($urandom_range(0, 2) != 0);
                default: fd_ready = ~fd_ready;
            endcase
            case (md_mode)
                0:       md_ready = 1'b1;
                1:       md_ready = ($urandom_range(0, 1) != 0);
                default: md_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [BW-1:0] cur, prev_fd, e;
        logic [DW-1:0] prev_md;
        logic [63:0]   em;
        bit fd_stall, md_stall;
        fd_stall = 1'b0;
        md_stall = 1'b0;
        prev_fd = '0;
        prev_md = '0;
        forever begin
            @(negedge clk);
            cur = {fd_last, fd_keep, fd_data};
            if (!resetn) begin
                fd_stall = 1'b0;
                md_stall = 1'b0;
                continue;
            end
            if (fd_stall) check("fd_hold", 640'({fd_valid, cur}), 640'({1'b1, prev_fd}));
            if (md_stall) check("md_hold", 640'({md_valid, md_data}), 640'({1'b1, prev_md}));
            check("in_ready_exclusive", 640'(in1_ready & in2_ready), 640'(0));
            if (fd_valid && !fd_ready) check("in_ready_stall", 640'({in1_ready, in2_ready}), 640'(0));
            if (fd_valid && fd_ready) begin
                if (!mon_in_frame) begin
                    mon_src = fd_data[0];
                    mon_in_frame = 1'b1;
                    if (order_rec) obs_order.push_back(fd_data[0]);
                end
                if ((mon_src ? exp2_q.size() : exp1_q.size()) == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL fd_extra: got beat for src %0d, required none pending", mon_src);
                end else begin
                    e = mon_src ? exp2_q.pop_front() : exp1_q.pop_front();
                    check(mon_src ? "fd_beat_in2" : "fd_beat_in1", 640'(cur), 640'(e));
                end
                if (fd_last) mon_in_frame = 1'b0;
            end
            if (md_valid && md_ready) begin
                last_md = md_data;
                if ((md_data[48] ? md2_q.size() : md1_q.size()) == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL md_extra: got md %h, required none pending", md_data[63:0]);
                end else begin
                    em = md_data[48] ? md2_q.pop_front() : md1_q.pop_front();
                    check("md_beat", 640'(md_data), 640'(em));
                end
            end
            fd_stall = fd_valid && !fd_ready;
            prev_fd  = cur;
            md_stall = md_valid && !md_ready;
            prev_md  = md_data;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_drain(input string name);
        int wc;
        wc = 0;
        while ((tx1_q.size() + tx2_q.size() + exp1_q.size() + exp2_q.size() +
                md1_q.size() + md2_q.size()) != 0 && wc < 5000) begin
            @(negedge clk);
            wc++;
        end
        check(name, 640'(tx1_q.size() + tx2_q.size() + exp1_q.size() + exp2_q.size() +
                         md1_q.size() + md2_q.size()), 640'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_fd"}, 640'({fd_valid, fd_last, fd_keep, fd_data}), 640'(0));
        check({name, "_md"}, 640'({md_valid, md_data}), 640'(0));
        check({name, "_in_ready"}, 640'({in1_ready, in2_ready}), 640'(0));
        check({name, "_state"}, 640'(dbg_state), 640'(IDLE));
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        flush_sb();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit exp_ord[4];
        int t0;
        int hs_cyc[$];
        logic [BW-1:0] beats[5];
        int n, wc;
        bit hs;

        frame_size = 32'd1024;
        in1_data = '0; in1_keep = '0; in1_last = 1'b0; in1_valid = 1'b0;
        in2_data = '0; in2_keep = '0; in2_last = 1'b0; in2_valid = 1'b0;

        apply_reset();
        @(negedge clk);
        check_outputs_zero("reset");

        // Arbitration: both inputs valid straight out of reset.
`ifdef DATA_MERGE_STRICT_PRIORITY_EN
        exp_ord = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
        exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        for (int f = 0; f < 2; f++) begin
            build_frame(1'b0, 2, 0, {KW{1'b1}});
            build_frame(1'b1, 2, 0, {KW{1'b1}});
        end
        obs_order.delete();
        order_rec = 1'b1;
        @(negedge clk);
        drv_hold = 1'b0;
        wait_drain("arb_drain");
        order_rec = 1'b0;
        check("arb_frames", 640'(obs_order.size()), 640'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < obs_order.size()) check("arb_order", 640'(obs_order[i]), 640'(exp_ord[i]));
        end

        // Four full beats on IN1: latency and back-to-back output.
        build_frame(1'b0, 4, 0, {KW{1'b1}});
        t0 = -1;
        hs_cyc.delete();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (t0 < 0 && in1_valid) t0 = cyc;
            if (fd_valid && fd_ready) hs_cyc.push_back(cyc);
        end
        check("lat_beats", 640'(hs_cyc.size()), 640'(4));
        if (hs_cyc.size() == 4) begin
            check("lat_first", 640'(hs_cyc[0] - t0), 640'(2));
            check("lat_span", 640'(hs_cyc[3] - hs_cyc[0]), 640'(3));
        end
        wait_drain("full_drain");
        check("full_md", 640'(last_md[50:0]), 640'({1'b0, 1'b0, 1'b0, 16'd4, 32'd256}));

        // Short last beat against the oversize threshold.
        frame_size = 32'd100;
        build_frame(1'b0, 2, 0, 64'h0000_0000_0000_00FF);
        wait_drain("keep_drain_a");
        check("keep_md_a", 640'({last_md[49], last_md[31:0]}), 640'({1'b0, 32'd72}));
        frame_size = 32'd64;
        build_frame(1'b0, 2, 0, 64'h0000_0000_0000_00FF);
        wait_drain("keep_drain_b");
        check("keep_md_b", 640'({last_md[49], last_md[31:0]}), 640'({1'b1, 32'd72}));
        frame_size = 32'd1024;

        // Toggling downstream ready during a 6-beat frame.
        fd_mode = 2;
        build_frame(1'b0, 6, 0, {KW{1'b1}});
        wait_drain("toggle_drain");
        fd_mode = 0;

        // Metadata sink stuck low across two frames.
        md_mode = 2;
        build_frame(1'b0, 2, 0, {KW{1'b1}});
        build_frame(1'b0, 2, 0, {KW{1'b1}});
        wc = 0;
        while (exp1_q.size() != 0 && wc < 200) begin @(negedge clk); wc++; end
        check("mdstall_data_passed", 640'(exp1_q.size()), 640'(0));
        build_frame(1'b1, 2, 0, {KW{1'b1}});
        repeat (6) @(negedge clk);
        check("mdstall_state", 640'(dbg_state), 640'(META));
        check("mdstall_no_grant", 640'({in1_ready, in2_ready}), 640'(0));
        check("mdstall_in2_waiting", 640'(exp2_q.size()), 640'(2));
        check("mdstall_md_pending", 640'({md_valid, md1_q.size()}), 640'({1'b1, 32'd2}));
        md_mode = 0;
        wait_drain("mdstall_drain");

        // Random traffic with backpressure on both sinks.
        gap_en = 1'b1;
        fd_mode = 1;
        md_mode = 1;
        for (int batch = 0; batch < 4; batch++) begin
            frame_size = 32'($urandom_range(16, 400));
            for (int f = 0; f < 10; f++) begin
                build_frame(1'($urandom_range(0, 1)), $urandom_range(1, 8), 1, '0);
            end
            wait_drain("rand_drain");
        end
        gap_en = 1'b0;
        fd_mode = 0;
        md_mode = 0;
        frame_size = 32'd1024;
        repeat (3) @(negedge clk);

        // Reset pulse while beat 3 of a 5-beat frame is presented.
        drv_hold = 1'b1;
        @(negedge clk);
        build_frame(1'b0, 5, 0, {KW{1'b1}});
        for (int i = 0; i < 5; i++) beats[i] = tx1_q.pop_front();
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, beats[0]);
        n = 0;
        wc = 0;
        while (n < 2 && wc < 50) begin
            @(negedge clk);
            hs = in1_ready;
            @(posedge clk); #1;
            wc++;
            if (hs) begin
                n++;
                set_port(1'b0, 1'b1, beats[n]);
            end
        end
        check("rst_pre_beats", 640'(n), 640'(2));
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        set_port(1'b0, 1'b0, '0);
        flush_sb();
        @(negedge clk);
        check_outputs_zero("mid_reset");
        repeat (5) @(negedge clk);
        check("mid_reset_no_md", 640'(md_valid), 640'(0));
        drv_hold = 1'b0;
        build_frame(1'b0, 3, 0, 64'h0000_0000_0000_FFFF);
        wait_drain("post_reset_drain");
        check("post_reset_md", 640'(last_md[50:0]), 640'({1'b0, 1'b0, 1'b0, 16'd3, 32'd144}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_merge.md
# data_merge

Frame-atomic 2:1 AXI-Stream merger: the return-path counterpart of `data_switch`. It accepts frames on two input streams, IN1 and IN2. It forwards one whole frame at a time onto a single frame-data output. After each frame it emits one metadata beat on a separate metadata stream, recording the source, beat count and byte count. It sits downstream of the two `data_switch` output branches and recombines them toward the host-side DMA.

## Interface
- `DW`, default 512: stream data width in bits; must be a multiple of 8 and no greater than 512.
- `clk`  in  1  clock; all logic is on the rising edge.
- `resetn`  in  1  reset; synchronous, active-low.
- `FRAME_SIZE`  in  32  expected maximum frame size in bytes; used only for the oversize flag.
- `AXIS_IN1_TDATA`/`TKEEP`/`TLAST`/`TVALID`  in  DW/DW/8/1/1  input stream 1.
- `AXIS_IN1_TREADY`  out  1  ready for input stream 1.
- `AXIS_IN2_TDATA`/`TKEEP`/`TLAST`/`TVALID`  in  DW/DW/8/1/1  input stream 2.
- `AXIS_IN2_TREADY`  out  1  ready for input stream 2.
- `AXIS_OUT_FD_TDATA`/`TKEEP`/`TLAST`/`TVALID`  out  DW/DW/8/1/1  merged frame-data output; all registered.
- `AXIS_OUT_FD_TREADY`  in  1  downstream ready for frame data.
- `AXIS_OUT_MD_TDATA`  out  DW  metadata beat; registered.
- `AXIS_OUT_MD_TVALID`  out  1  metadata valid; registered.
- `AXIS_OUT_MD_TREADY`  in  1  downstream ready for metadata.

## Operation
- States:
  - IDLE: arbitrate between the inputs.
  - PASS: forward the granted input.
  - META: publish the metadata beat.
- IDLE:
  - If exactly one input has TVALID, grant it.
  - If both have TVALID, grant the input not served last (round-robin).
  - Move to PASS on the next cycle and clear the beat and byte counters.
- PASS:
  - Granted input: `TREADY = !OUT_FD_TVALID || OUT_FD_TREADY`.
  - Non-granted input: TREADY stays 0.
  - Each accepted beat loads the output register with TDATA/TKEEP/TLAST.
  - Each accepted beat increments the beat count, saturating at 16'hFFFF.
  - Each accepted beat adds popcount(TKEEP) to the byte count, saturating at 32'hFFFFFFFF.
  - An accepted beat with TLAST=1 moves to META.
- META:
  - If `!MD_TVALID || MD_TREADY`, load the metadata register, assert MD_TVALID, record the last-served input, and go to IDLE.
  - Otherwise hold in META.
- Metadata layout (all other bits 0):
  - [31:0] byte count.
  - [47:32] beat count.
  - [48] source: 0 = IN1, 1 = IN2.
  - [49] oversize: byte count > FRAME_SIZE.
  - [50] TKEEP-gap: a non-final beat of the frame had TKEEP ≠ all-ones.
- Frames are never interleaved on the output; OUT_FD TLAST marks exactly the source frame's last beat.
- A beat with TKEEP = 0 is forwarded and counted as a beat with 0 bytes.

## Timing
- Reset values:
  - All TVALID and TREADY outputs are 0.
  - TDATA, TKEEP and TLAST outputs are 0.
  - State is IDLE and the counters are 0.
  - Last-served is IN2, so IN1 wins the first tie.
- Data latency: an input beat accepted at edge N appears on OUT_FD at N+1.
- Throughput: one beat per cycle within a frame while OUT_FD_TREADY = 1.
- Per-frame overhead: 2 cycles minimum (one IDLE, one META), so back-to-back frames have 2 bubble cycles.
- AXIS stability:
  - OUT_FD and OUT_MD hold data and TVALID unchanged while TVALID=1 and TREADY=0.
  - Input TREADY never depends combinationally on input TVALID.
- Metadata is loaded on the cycle after the frame's last input beat is accepted. It can therefore become valid before or at the same time as the output TLAST beat; downstream must not assume any ordering between the two streams.
- Reset asserted mid-frame:
  - Everything is cleared immediately and the partial frame is dropped without TLAST.
  - No metadata is emitted for the dropped frame.
  - Upstream sources are responsible for their own resynchronisation.
- A TVALID arriving on one input while the other input is in PASS waits; it is granted next if still valid.

## Configuration
- `DATA_MERGE_STRICT_PRIORITY_EN`:
  - Defined: IN1 always wins when both inputs are valid in IDLE, and the last-served state is unused.
  - Undefined (default): round-robin as described above.
- Metadata format and timing are identical in both modes.

## Structure
- Package `data_merge_pkg` holds:
  - the state enum (IDLE, PASS, META);
  - metadata field offsets and widths (byte count, beat count, source, oversize, gap);
  - source constants `SRC_IN1 = 0` and `SRC_IN2 = 1`;
  - beat and byte saturation limits.
- Sub-module `keep_popcount`: combinational count of ones in `DW/8` TKEEP bits, output width `$clog2(DW/8)+1`.
- Everything else (arbiter, FSM, output register stage, metadata register) stays in `data_merge`.

## Test plan
- IN1 sends 4 full beats (DW = 512, TLAST on beat 4) with OUT_FD_TREADY = 1.
  - OUT_FD shows 4 beats on consecutive cycles, starting 2 cycles after the first TVALID.
  - MD shows bytes = 256, beats = 4, src = 0, oversize = 0.
- IN1 and IN2 both valid from reset, 2-beat frames each, round-robin build.
  - Output frame order is IN1, IN2, IN1, IN2 with no interleaving.
  - With `DATA_MERGE_STRICT_PRIORITY_EN` defined, all IN1 frames come first.
- Last beat has TKEEP = 64'h0000_0000_0000_00FF and FRAME_SIZE = 100 on a 2-beat frame.
  - MD shows bytes = 72, oversize = 0.
  - Repeating with FRAME_SIZE = 64 gives oversize = 1.
- OUT_FD_TREADY toggles 1-0-1-0 during a 6-beat frame.
  - No beat is lost or duplicated; TDATA is stable while stalled.
  - IN TREADY is low on each stall cycle.
- OUT_MD_TREADY held at 0 across two frames.
  - The second frame's data passes through; the FSM stays in META.
  - Neither input receives a grant until MD_TREADY = 1, after which the second MD beat follows.
- resetn = 0 for 1 cycle at beat 3 of a 5-beat frame.
  - All outputs return to 0 the next cycle and no MD beat is emitted.
  - A new frame after reset is handled normally.
